// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial full subtractor. Computes {bout, diff} = a - b - bin over WIDTH
//   bits, one bit per clock, LSB first, through a single 1-bit subtract cell
//   with a registered borrow. An accepted operation takes WIDTH RUN cycles
//   plus one DONE cycle before the next operands can be accepted.
//
// Handshake: operands transfer on a rising edge where start_valid and
//   start_ready are both high. start_ready is high only in IDLE. start_valid
//   seen in any other state is ignored; nothing is queued.
//
// Ports
//   clk          in   1      clock, rising edge
//   rst          in   1      synchronous reset, active-high
//   start_valid  in   1      a, b, bin valid this cycle
//   start_ready  out  1      ready to accept operands (IDLE only)
//   a            in   WIDTH  minuend, sampled on accept
//   b            in   WIDTH  subtrahend, sampled on accept
//   bin          in   1      borrow-in, sampled on accept
//   diff         out  WIDTH  (a - b - bin) mod 2^WIDTH, held until next result
//   bout         out  1      borrow-out, 1 iff a < b + bin
//   done         out  1      one-cycle pulse when diff/bout are new
//   busy         out  1      high in RUN and DONE
//   dbg_state    out  2      current FSM state (0 IDLE, 1 RUN, 2 DONE)
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             done,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic [WIDTH-1:0]   d_sh_q, d_sh_d;
    logic               brw_q, brw_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic               bout_q, bout_d;
    logic               done_q, done_d;

    // The single subtract cell operating on the current LSBs.
    logic               d_bit;
    logic               brw_nxt;
    logic [WIDTH-1:0]   d_sh_shift;

    assign d_bit   = a_sh_q[0] ^ b_sh_q[0] ^ brw_q;
    assign brw_nxt = (~a_sh_q[0] & b_sh_q[0]) | (~(a_sh_q[0] ^ b_sh_q[0]) & brw_q);

    // New difference bit enters at the MSB; after WIDTH shifts bit 0 of the
    // result has reached position 0. WIDTH=1 has no upper bits to keep.
    generate
        if (WIDTH == 1) begin : g_w1
            assign d_sh_shift = d_bit;
        end else begin : g_wn
            assign d_sh_shift = {d_bit, d_sh_q[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            d_sh_q  <= '0;
            brw_q   <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            d_sh_q  <= d_sh_d;
            brw_q   <= brw_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        d_sh_d  = d_sh_q;
        brw_d   = brw_q;
        cnt_d   = cnt_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_valid) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    brw_d   = bin;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                d_sh_d = d_sh_shift;
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                brw_d  = brw_nxt;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    diff_d  = d_sh_shift;
                    bout_d  = brw_nxt;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign start_ready = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign diff        = diff_q;
    assign bout        = bout_q;
    assign done        = done_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

    logic       clk;
    logic       rst;

    // WIDTH=8 instance
    logic       sv8, rdy8, bin8, bout8, done8, busy8;
    logic [7:0] a8, b8, diff8;
    logic [1:0] st8;

    // WIDTH=3 instance
    logic       sv3, rdy3, bin3, bout3, done3, busy3;
    logic [2:0] a3, b3, diff3;
    logic [1:0] st3;

    int checks;
    int failures;
    logic [3:0] exp_q[$];

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start_valid(sv8), .start_ready(rdy8),
        .a(a8), .b(b8), .bin(bin8), .diff(diff8), .bout(bout8),
        .done(done8), .busy(busy8), .dbg_state(st8)
    );

    serial_subtractor #(.WIDTH(3)) dut3 (
        .clk(clk), .rst(rst), .start_valid(sv3), .start_ready(rdy3),
        .a(a3), .b(b3), .bin(bin3), .diff(diff3), .bout(bout3),
        .done(done3), .busy(busy3), .dbg_state(st3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one WIDTH=8 operation and checks handshake, latency, result,
    // pulse width and that the result is held afterwards.
    task automatic run8(input string name, input logic [7:0] ta, input logic [7:0] tb_v,
                        input logic tbin, input logic [7:0] ed, input logic eb);
        int  n;
        bit  seen;
        @(negedge clk);
        a8 = ta; b8 = tb_v; bin8 = tbin; sv8 = 1'b1;
        checks++;
        if (rdy8 !== 1'b1) begin
            failures++;
            $display("FAIL %s ready_before_accept got=%b exp=1", name, rdy8);
        end
        @(posedge clk); #1;
        sv8 = 1'b0;
        checks++;
        if (busy8 !== 1'b1 || rdy8 !== 1'b0) begin
            failures++;
            $display("FAIL %s busy_after_accept got busy=%b ready=%b exp busy=1 ready=0", name, busy8, rdy8);
        end
        n = 0; seen = 0;
        while (!seen && n < 20) begin
            @(posedge clk); #1;
            n++;
            if (done8 === 1'b1) seen = 1;
        end
        checks++;
        if (!seen || n != 8) begin
            failures++;
            $display("FAIL %s done_latency got=%0d seen=%0d exp=8", name, n, seen);
        end
        checks++;
        if (diff8 !== ed) begin
            failures++;
            $display("FAIL %s diff got=%h exp=%h", name, diff8, ed);
        end
        checks++;
        if (bout8 !== eb) begin
            failures++;
            $display("FAIL %s bout got=%b exp=%b", name, bout8, eb);
        end
        @(posedge clk); #1;
        checks++;
        if (done8 !== 1'b0 || rdy8 !== 1'b1 || busy8 !== 1'b0) begin
            failures++;
            $display("FAIL %s done_pulse got done=%b ready=%b busy=%b exp 0 1 0", name, done8, rdy8, busy8);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (diff8 !== ed || bout8 !== eb) begin
            failures++;
            $display("FAIL %s result_hold got=%b_%h exp=%b_%h", name, bout8, diff8, eb, ed);
        end
    endtask

    task automatic test_reset();
        checks++;
        if (diff8 !== 8'h00 || bout8 !== 1'b0 || done8 !== 1'b0 || busy8 !== 1'b0 || rdy8 !== 1'b1) begin
            failures++;
            $display("FAIL reset_w8 got diff=%h bout=%b done=%b busy=%b ready=%b exp 00 0 0 0 1",
                     diff8, bout8, done8, busy8, rdy8);
        end
        checks++;
        if (diff3 !== 3'h0 || bout3 !== 1'b0 || done3 !== 1'b0 || busy3 !== 1'b0 || rdy3 !== 1'b1) begin
            failures++;
            $display("FAIL reset_w3 got diff=%h bout=%b done=%b busy=%b ready=%b exp 0 0 0 0 1",
                     diff3, bout3, done3, busy3, rdy3);
        end
    endtask

    task automatic test_basic();
        run8("sub_5_3", 8'd5, 8'd3, 1'b0, 8'h02, 1'b0);
    endtask

    task automatic test_borrow();
        run8("sub_3_5", 8'd3, 8'd5, 1'b0, 8'hFE, 1'b1);
        run8("sub_0_0_bin", 8'd0, 8'd0, 1'b1, 8'hFF, 1'b1);
    endtask

    // Reset four cycles into a run: outputs clear, no done, then a fresh op.
    task automatic test_abort_reset();
        int dones;
        @(negedge clk);
        a8 = 8'h55; b8 = 8'h11; bin8 = 1'b0; sv8 = 1'b1;
        @(posedge clk); #1;
        sv8 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (diff8 !== 8'h00 || bout8 !== 1'b0 || done8 !== 1'b0 || busy8 !== 1'b0 || rdy8 !== 1'b1) begin
            failures++;
            $display("FAIL abort_outputs got diff=%h bout=%b done=%b busy=%b ready=%b exp 00 0 0 0 1",
                     diff8, bout8, done8, busy8, rdy8);
        end
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done8 === 1'b1) dones++;
        end
        checks++;
        if (dones != 0) begin
            failures++;
            $display("FAIL abort_no_done got=%0d exp=0", dones);
        end
        run8("after_abort", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0);
    endtask

    // start_valid held through part of RUN with changing operands.
    task automatic test_hold_valid();
        int dones;
        int bad_ready;
        logic [7:0] got_d;
        logic       got_b;
        @(negedge clk);
        a8 = 8'hFF; b8 = 8'hFF; bin8 = 1'b0; sv8 = 1'b1;
        @(posedge clk); #1;
        bad_ready = 0;
        dones = 0;
        got_d = 8'hAA; got_b = 1'b1;
        for (int i = 0; i < 5; i++) begin
            a8 = 8'(i * 37 + 1); b8 = 8'(200 - i * 13); bin8 = i[0];
            if (rdy8 !== 1'b0) bad_ready++;
            @(posedge clk); #1;
            if (done8 === 1'b1) dones++;
        end
        sv8 = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (done8 === 1'b1) begin
                dones++;
                got_d = diff8;
                got_b = bout8;
            end
        end
        checks++;
        if (bad_ready != 0) begin
            failures++;
            $display("FAIL hold_ready_low got=%0d high_cycles exp=0", bad_ready);
        end
        checks++;
        if (dones != 1) begin
            failures++;
            $display("FAIL hold_one_done got=%0d exp=1", dones);
        end
        checks++;
        if (got_d !== 8'h00 || got_b !== 1'b0) begin
            failures++;
            $display("FAIL hold_result got=%b_%h exp=0_00", got_b, got_d);
        end
    endtask

    // WIDTH=3: every (a, b, bin) issued at the earliest acceptance edge.
    task automatic test_back_to_back();
        int         guard;
        int         r;
        int         n;
        int         prev_edge;
        int         edge_cnt;
        logic [3:0] exp;
        logic [2:0] ta, tb_v;
        logic       tbin;
        prev_edge = -1;
        edge_cnt  = 0;
        for (int v = 0; v < 128; v++) begin
            ta = 3'(v >> 4); tb_v = 3'(v >> 1); tbin = v[0];
            r = int'(ta) - int'(tb_v) - int'(tbin);
            exp = {(r < 0) ? 1'b1 : 1'b0, 3'(r & 7)};
            exp_q.push_back(exp);
            @(negedge clk);
            a3 = ta; b3 = tb_v; bin3 = tbin; sv3 = 1'b1;
            guard = 0;
            while (rdy3 !== 1'b1 && guard < 10) begin
                @(negedge clk);
                edge_cnt++;
                guard++;
            end
            @(posedge clk); #1;
            edge_cnt++;
            sv3 = 1'b0;
            if (prev_edge >= 0) begin
                checks++;
                if (edge_cnt - prev_edge != 5) begin
                    failures++;
                    $display("FAIL b2b_spacing vec=%0d got=%0d exp=5", v, edge_cnt - prev_edge);
                end
            end
            prev_edge = edge_cnt;
            n = 0;
            while (done3 !== 1'b1 && n < 10) begin
                @(posedge clk); #1;
                edge_cnt++;
                n++;
            end
            exp = exp_q.pop_front();
            checks++;
            if (done3 !== 1'b1 || {bout3, diff3} !== exp || n != 3) begin
                failures++;
                $display("FAIL b2b_result a=%0d b=%0d bin=%0d got=%b_%h lat=%0d exp=%b_%h lat=3",
                         ta, tb_v, tbin, bout3, diff3, n, exp[3], exp[2:0]);
            end
        end
    endtask

    initial begin
        checks = 0; failures = 0;
        rst = 1'b1;
        sv8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
        sv3 = 1'b0; a3 = '0; b3 = '0; bin3 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst = 1'b0;
        test_basic();
        test_borrow();
        test_abort_reset();
        test_hold_valid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
